// File: rtl/kpscan_pkg.sv
// Shared types, column/key constants and key-code mapping for the 4x4 keypad scanner.
package kpscan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam int KP_W = 4;

  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Rotate the single low bit one place to the right, wrapping 1110 -> 0111.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    return {col[0], col[3:1]};
  endfunction

  function automatic logic row_valid(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Pattern is {column drive, synchronised rows}; rows ordered as the columns.
  function automatic logic [3:0] key_map(input logic [7:0] pat);
    logic [3:0] code;
    case (pat)
      {COL0, COL0}: code = 4'd1;
      {COL0, COL1}: code = 4'd4;
      {COL0, COL2}: code = 4'd7;
      {COL0, COL3}: code = KEY_STAR;
      {COL1, COL0}: code = 4'd2;
      {COL1, COL1}: code = 4'd5;
      {COL1, COL2}: code = 4'd8;
      {COL1, COL3}: code = 4'd0;
      {COL2, COL0}: code = 4'd3;
      {COL2, COL1}: code = 4'd6;
      {COL2, COL2}: code = 4'd9;
      {COL2, COL3}: code = KEY_HASH;
      {COL3, COL0}: code = KEY_A;
      {COL3, COL1}: code = KEY_B;
      {COL3, COL2}: code = KEY_C;
      {COL3, COL3}: code = KEY_D;
      default:      code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/kpscan_sync.sv
// kp_sync2: two-flop synchroniser for the asynchronous keypad row pins (idle high).
module kp_sync2
  import kpscan_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [KP_W-1:0] d,
  output logic [KP_W-1:0] q
);

  logic [KP_W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kpscan.sv
// kpscan: 4x4 keypad column scanner with debounce and valid/ack key events.
// Optional auto-repeat while a key is held: define KPSCAN_REPEAT_EN.
module kpscan
  import kpscan_pkg::*;
#(
`ifdef KPSCAN_REPEAT_EN
  parameter int REPEAT_CNT   = 25,
`endif
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  state_t        state, state_n;
  logic [3:0]    rs;
  logic [DW-1:0] div, div_n;
  logic [CW-1:0] dcnt, dcnt_n;
  logic [7:0]    cand, cand_n;
  logic [3:0]    kpc_n, key_code_n;
  logic          key_valid_n, key_held_n, overrun_n;
  logic          strobe, issue;
`ifdef KPSCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  logic [RW-1:0] rcnt, rcnt_n;
`endif

  kp_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (kpr),
    .q       (rs)
  );

  // kpc only moves on a strobe, when the divider wraps anyway, so the
  // divider restart on a column change needs no extra logic.
  assign strobe = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SCAN;
      kpc       <= COL0;
      div       <= '0;
      dcnt      <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
`ifdef KPSCAN_REPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      kpc       <= kpc_n;
      div       <= div_n;
      dcnt      <= dcnt_n;
      cand      <= cand_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
      overrun   <= overrun_n;
`ifdef KPSCAN_REPEAT_EN
      rcnt      <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    kpc_n       = kpc;
    div_n       = strobe ? '0 : div + 1'b1;
    dcnt_n      = dcnt;
    cand_n      = cand;
    key_code_n  = key_code;
    key_valid_n = key_valid;
    key_held_n  = key_held;
    overrun_n   = overrun;
    issue       = 1'b0;
`ifdef KPSCAN_REPEAT_EN
    rcnt_n      = rcnt;
`endif

    // Ack is applied before any new event so a coincident press is not an overrun.
    if (key_valid && key_ack)
      key_valid_n = 1'b0;

    case (state)
      SCAN: begin
        if (strobe) begin
          if (row_valid(rs)) begin
            cand_n  = {kpc, rs};
            dcnt_n  = CW'(1);
            state_n = DEBOUNCE;
          end else begin
            kpc_n = next_col(kpc);
          end
        end
      end
      DEBOUNCE: begin
        if (strobe) begin
          if (rs == cand[3:0]) begin
            if (dcnt == CW'(DEBOUNCE_CNT - 1)) begin
              state_n    = PRESSED;
              dcnt_n     = '0;
              key_held_n = 1'b1;
              issue      = 1'b1;
`ifdef KPSCAN_REPEAT_EN
              rcnt_n     = '0;
`endif
            end else begin
              dcnt_n = dcnt + 1'b1;
            end
          end else begin
            state_n = SCAN;
            kpc_n   = next_col(kpc);
          end
        end
      end
      PRESSED: begin
        if (strobe) begin
          if (rs == 4'b1111) begin
            if (dcnt == CW'(DEBOUNCE_CNT - 1)) begin
              state_n    = SCAN;
              dcnt_n     = '0;
              key_held_n = 1'b0;
              kpc_n      = next_col(kpc);
            end else begin
              dcnt_n = dcnt + 1'b1;
            end
          end else begin
            dcnt_n = '0;
          end
`ifdef KPSCAN_REPEAT_EN
          if (rs == cand[3:0]) begin
            if (rcnt == RW'(REPEAT_CNT - 1)) begin
              rcnt_n = '0;
              issue  = 1'b1;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end else begin
            rcnt_n = '0;
          end
`endif
        end
      end
      default: begin
        state_n = SCAN;
        dcnt_n  = '0;
      end
    endcase

    if (issue) begin
      if (key_valid_n) begin
        overrun_n = 1'b1;
      end else begin
        key_valid_n = 1'b1;
        key_code_n  = key_map(cand);
      end
    end
  end

endmodule

// File: tb/tb_kpscan.sv
// Directed self-checking bench for kpscan with SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_kpscan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  // Keypad model: one key shorts key_col to key_row, or a raw row override.
  logic       key_dn;
  logic [3:0] key_col, key_row;
  logic       raw_en;
  logic [3:0] raw_kpr;

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  logic [3:0] cols [4];
  logic [3:0] exp_col;

  assign kpr = raw_en ? raw_kpr : ((key_dn && kpc == key_col) ? key_row : 4'b1111);

  kpscan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kpr       (kpr),
    .kpc       (kpc),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // k = index of the posedge just before the current negedge, E0 = first edge out of reset.
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    key_dn  = 1'b0;
    raw_en  = 1'b0;
    key_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    k = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    key_dn  = 1'b0;
    raw_en  = 1'b0;
    key_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (kpc !== 4'b0111) begin n_fail++; $display("FAIL reset_kpc got=%b exp=0111", kpc); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held got=%b exp=0", key_held); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      exp_col = cols[((k + 1) / 4) % 4];
      n_checks++; if (kpc !== exp_col) begin n_fail++; $display("FAIL idle_kpc k=%0d got=%b exp=%b", k, kpc, exp_col); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid k=%0d got=%b exp=0", k, key_valid); end
    end
  endtask

  task automatic test_press_ack_release();
    do_reset();
    key_dn = 1'b1; key_col = 4'b1011; key_row = 4'b1011;
    key_ack = 1'b1;  // ignored while key_valid=0
    while (k < 14) begin
      step();
      if (k == 10) key_ack = 1'b0;
      exp_col = (k < 3) ? 4'b0111 : 4'b1011;
      n_checks++; if (kpc !== exp_col) begin n_fail++; $display("FAIL press_kpc k=%0d got=%b exp=%b", k, kpc, exp_col); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_early_valid k=%0d got=%b exp=0", k, key_valid); end
    end
    step();  // k=15
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid got=%b exp=1", key_valid); end
    n_checks++; if (key_code !== 4'd5) begin n_fail++; $display("FAIL press_code got=%0d exp=5", key_code); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held got=%b exp=1", key_held); end
    n_checks++; if (kpc !== 4'b1011) begin n_fail++; $display("FAIL press_kpc_hold got=%b exp=1011", kpc); end
    key_ack = 1'b1;
    step();  // k=16
    key_ack = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid got=%b exp=0", key_valid); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL ack_held got=%b exp=1", key_held); end
    key_dn = 1'b0;
    while (k < 26) step();
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rel_held_early got=%b exp=1", key_held); end
    n_checks++; if (kpc !== 4'b1011) begin n_fail++; $display("FAIL rel_kpc_early got=%b exp=1011", kpc); end
    step();  // k=27
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rel_held got=%b exp=0", key_held); end
    n_checks++; if (kpc !== 4'b1101) begin n_fail++; $display("FAIL rel_kpc got=%b exp=1101", kpc); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid got=%b exp=0", key_valid); end
    while (k < 31) step();
    n_checks++; if (kpc !== 4'b1110) begin n_fail++; $display("FAIL rescan_kpc got=%b exp=1110", kpc); end
  endtask

  task automatic test_bounce();
    do_reset();
    key_dn = 1'b1; key_col = 4'b1101; key_row = 4'b0111;
    while (k < 15) step();
    key_dn = 1'b0;
    n_checks++; if (kpc !== 4'b1101) begin n_fail++; $display("FAIL bounce_kpc_hold got=%b exp=1101", kpc); end
    while (k < 24) begin
      step();
      exp_col = (k < 19) ? 4'b1101 : ((k < 23) ? 4'b1110 : 4'b0111);
      n_checks++; if (kpc !== exp_col) begin n_fail++; $display("FAIL bounce_kpc k=%0d got=%b exp=%b", k, kpc, exp_col); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_valid k=%0d got=%b exp=0", k, key_valid); end
    end
  endtask

  task automatic test_ghost();
    do_reset();
    raw_en = 1'b1; raw_kpr = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_col = cols[((k + 1) / 4) % 4];
      n_checks++; if (kpc !== exp_col) begin n_fail++; $display("FAIL ghost_kpc k=%0d got=%b exp=%b", k, kpc, exp_col); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ghost_valid k=%0d got=%b exp=0", k, key_valid); end
    end
    raw_en = 1'b0;
  endtask

  // Press 5, release without ack, then press 9; optionally ack on the confirming edge.
  task automatic press5_then9(input logic ack_at_confirm);
    do_reset();
    key_dn = 1'b1; key_col = 4'b1011; key_row = 4'b1011;
    while (k < 16) step();
    key_col = 4'b1101; key_row = 4'b1101;
    while (k < 27) step();
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL p9_held_gap got=%b exp=0", key_held); end
    n_checks++; if (kpc !== 4'b1101) begin n_fail++; $display("FAIL p9_kpc got=%b exp=1101", kpc); end
    while (k < 38) step();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL p9_overrun_early got=%b exp=0", overrun); end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL p9_valid_early got=%b exp=1", key_valid); end
    key_ack = ack_at_confirm;
    step();  // k=39
    key_ack = 1'b0;
  endtask

  task automatic test_overrun();
    press5_then9(1'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_overrun got=%b exp=1", overrun); end
    n_checks++; if (key_code !== 4'd5) begin n_fail++; $display("FAIL ovr_code got=%0d exp=5", key_code); end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", key_valid); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL ovr_held got=%b exp=1", key_held); end
  endtask

  task automatic test_reset_in_pressed();
    reset_n = 1'b0;
    step();
    n_checks++; if (kpc !== 4'b0111) begin n_fail++; $display("FAIL rstp_kpc got=%b exp=0111", kpc); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_valid got=%b exp=0", key_valid); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rstp_held got=%b exp=0", key_held); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstp_overrun got=%b exp=0", overrun); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL rstp_code got=%0d exp=0", key_code); end
    reset_n = 1'b1;
    key_dn  = 1'b0;
  endtask

  task automatic test_ack_collision();
    press5_then9(1'b1);
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid got=%b exp=1", key_valid); end
    n_checks++; if (key_code !== 4'd9) begin n_fail++; $display("FAIL coll_code got=%0d exp=9", key_code); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coll_overrun got=%b exp=0", overrun); end
    step();
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid_hold got=%b exp=1", key_valid); end
  endtask

  initial begin
    cols[0] = 4'b0111; cols[1] = 4'b1011; cols[2] = 4'b1101; cols[3] = 4'b1110;
    reset_n = 1'b0;
    key_dn  = 1'b0; key_col = 4'b1111; key_row = 4'b1111;
    raw_en  = 1'b0; raw_kpr = 4'b1111;
    key_ack = 1'b0;
    k = 0;
    test_reset();
    test_idle_scan();
    test_press_ack_release();
    test_bounce();
    test_ghost();
    test_overrun();
    test_reset_in_pressed();
    test_ack_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
